prod_accum_pipe: RTL and testbench

PROD_ACCUM_PIPE -- requirements
Module: prod_accum_pipe

---
 rtl/prod_accum_pkg.sv | 18 +
 rtl/prod_accum_pipe.sv | 90 +++++++++
 tb/tb_prod_accum_pipe.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/prod_accum_pkg.sv
// Shared widths and state encoding for the product accumulator.
package prod_accum_pkg;

  localparam int PROD_W_DEF = 16;
  localparam int LEN_W_DEF  = 4;

  // Sixteen 8x8 products cannot exceed PROD_W + LEN_W bits.
  function automatic int acc_w(input int prod_w, input int len_w);
    return prod_w + len_w;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/prod_accum_pipe.sv
// Sums 1..16 multiplier products per request and holds the result until taken.
module prod_accum_pipe
  import prod_accum_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [LEN_W-1:0]        vec_len,
  input  logic                    prod_en_in,
  input  logic [PROD_W-1:0]       prod_in,
  input  logic                    acc_ready,
  output logic                    acc_valid,
  output logic [PROD_W+LEN_W-1:0] acc_out,
  output logic                    busy,
  output logic                    drop_err
);

  localparam int ACC_W = acc_w(PROD_W, LEN_W);

  state_t             state, state_nxt;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   cnt;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   prod_ext;
  logic               last_prod;

  assign prod_ext  = {{LEN_W{1'b0}}, prod_in};
  assign last_prod = prod_en_in && (cnt == len_q);
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start)                  state_nxt = ST_ACCUM;
      ST_ACCUM: if (last_prod)              state_nxt = ST_DONE;
      ST_DONE:  if (acc_valid && acc_ready) state_nxt = ST_IDLE;
      default:                              state_nxt = ST_IDLE;
    endcase
  end

  // acc_out is only written on completion, so partial sums never leak out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q     <= '0;
      cnt       <= '0;
      acc       <= '0;
      acc_out   <= '0;
      acc_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            len_q <= vec_len;
            cnt   <= '0;
            acc   <= '0;
          end
        end
        ST_ACCUM: begin
          if (last_prod) begin
            acc_out   <= acc + prod_ext;
            acc_valid <= 1'b1;
          end else if (prod_en_in) begin
            acc <= acc + prod_ext;
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: begin
          if (acc_valid && acc_ready) acc_valid <= 1'b0;
        end
        default: acc_valid <= 1'b0;
      endcase
    end
  end

  // A product landing on the accepted start is itself a drop, so it wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  drop_err <= 1'b0;
    else if (state == ST_IDLE && start)          drop_err <= prod_en_in;
    else if (prod_en_in && state != ST_ACCUM)    drop_err <= 1'b1;
  end

endmodule

// File: tb/tb_prod_accum_pipe.sv
// Self-checking bench: queue-based reference model plus directed and random runs.
module tb_prod_accum_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  vec_len = '0;
  logic        prod_en_in = 1'b0;
  logic [15:0] prod_in = '0;
  logic        acc_ready = 1'b1;
  logic        acc_valid;
  logic [19:0] acc_out;
  logic        busy;
  logic        drop_err;

  int tests = 0;
  int fails = 0;

  prod_accum_pipe dut (
    .clk(clk), .rst_n(rst_n), .start(start), .vec_len(vec_len),
    .prod_en_in(prod_en_in), .prod_in(prod_in), .acc_ready(acc_ready),
    .acc_valid(acc_valid), .acc_out(acc_out), .busy(busy), .drop_err(drop_err)
  );

  always #5 clk = ~clk;

  // Reference model: 0 = waiting for start, 1 = collecting, 2 = offering result.
  int          m_mode;
  int          m_len;
  int unsigned m_prods[$];
  int unsigned m_out;
  bit          m_valid;
  bit          m_drop;

  function automatic int unsigned qsum();
    int unsigned s = 0;
    foreach (m_prods[i]) s += m_prods[i];
    return s;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_len = 0; m_prods.delete();
    m_out = 0; m_valid = 0; m_drop = 0;
  endtask

  // Evaluated with the inputs that were present at the edge just taken.
  task automatic model_step();
    if (!rst_n) begin
      model_reset();
    end else if (m_mode == 0) begin
      if (start) begin
        m_len = int'(vec_len);
        m_prods.delete();
        m_drop = prod_en_in;
        m_mode = 1;
      end else if (prod_en_in) begin
        m_drop = 1;
      end
    end else if (m_mode == 1) begin
      if (prod_en_in) begin
        m_prods.push_back(int'(prod_in));
        if (m_prods.size() == m_len + 1) begin
          m_out = qsum();
          m_valid = 1;
          m_mode = 2;
        end
      end
    end else begin
      if (prod_en_in) m_drop = 1;
      if (acc_ready) begin
        m_valid = 0;
        m_mode = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  always @(negedge clk) begin
    tests++;
    if (acc_valid !== m_valid || acc_out !== 20'(m_out) ||
        busy !== (m_mode != 0) || drop_err !== m_drop) begin
      fails++;
      $display("FAIL cycle_cmp t=%0t: got v=%0b out=%0d busy=%0b drop=%0b, want v=%0b out=%0d busy=%0b drop=%0b",
               $time, acc_valid, acc_out, busy, drop_err,
               m_valid, m_out, (m_mode != 0), m_drop);
    end
  end

  task automatic check(input string name, input int unsigned got, input int unsigned want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic start_op(input int len);
    start = 1'b1; vec_len = 4'(len);
    tick();
    start = 1'b0;
  endtask

  task automatic send(input int unsigned p);
    prod_en_in = 1'b1; prod_in = 16'(p);
    tick();
    prod_en_in = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    tick(); tick();
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    tick(); tick();
    check("reset_out", acc_out, 0);
    check("reset_busy", busy, 0);
    rst_n = 1'b1;
    tick();

    // 4 products, result one edge after the last
    start_op(3);
    for (int i = 1; i <= 4; i++) send(i);
    check("sum4_valid", acc_valid, 1);
    check("sum4_out", acc_out, 10);
    check("sum4_model", m_out, 10);
    tick();

    // max-length full-scale, no wrap
    start_op(15);
    for (int i = 0; i < 16; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      send(65025);
    end
    check("max_out", acc_out, 1040400);
    check("max_model", m_out, 32'h0FE010);
    tick();

    // held result under backpressure
    acc_ready = 1'b0;
    start_op(0);
    send(16'hFFFF);
    check("hold_valid", acc_valid, 1);
    repeat (5) tick();
    check("hold_out", acc_out, 32'hFFFF);
    acc_ready = 1'b1;
    tick();
    check("hold_release_busy", busy, 0);
    check("hold_release_valid", acc_valid, 0);

    // drops in IDLE and DONE
    send(5);
    check("drop_idle", drop_err, 1);
    acc_ready = 1'b0;
    start_op(0);
    check("drop_cleared_by_start", drop_err, 0);
    send(7);
    send(9);
    check("drop_done", drop_err, 1);
    check("drop_done_out", acc_out, 7);
    acc_ready = 1'b1;
    tick();
    start_op(1);
    check("drop_cleared", drop_err, 0);
    send(1); send(2);
    check("two_sum", acc_out, 3);
    tick();

    // start pulses during ACCUM are ignored
    start_op(7);
    for (int i = 0; i < 8; i++) begin
      start = (i % 2 == 0); vec_len = 4'd1;
      send(100 + i);
      start = 1'b0;
    end
    check("ign_start_sum", acc_out, 828);
    tick();

    // reset mid-run, then a fresh run
    start_op(7);
    send(11); send(12); send(13);
    do_reset();
    check("rst_mid_out", acc_out, 0);
    check("rst_mid_busy", busy, 0);
    start_op(2);
    send(4); send(5); send(6);
    check("post_rst_sum", acc_out, 15);
    tick();

    // randomized traffic against the model
    for (int c = 0; c < 1500; c++) begin
      start      = ($urandom_range(0, 5) == 0);
      vec_len    = 4'($urandom_range(0, 15));
      prod_en_in = ($urandom_range(0, 2) != 0);
      prod_in    = 16'($urandom_range(0, 65025));
      acc_ready  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 299) == 0) begin
        start = 1'b0; prod_en_in = 1'b0;
        do_reset();
      end else begin
        tick();
      end
    end
    start = 1'b0; prod_en_in = 1'b0; acc_ready = 1'b1;
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
